// File: rtl/iloader_pkg.sv
// Shared definitions for the instruction loader: FSM states and
// instruction-memory geometry.
package iloader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam int unsigned IM_DEPTH   = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IM_ADDR_W  = 5;

endpackage

// File: rtl/word_assembler.sv
// Collects big-endian bytes into 32-bit words. The first byte of a word
// ends up in [31:24]; word_valid pulses on the cycle the final byte is
// presented, with word already containing that byte.
module word_assembler
  import iloader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);
  localparam int unsigned SH_W  = (WORD_BYTES - 1) * 8;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0] byte_cnt;
  logic [SH_W-1:0]  shreg;

  // Shift accepted bytes in and count position within the current word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_en) begin
      shreg <= {shreg[SH_W-9:0], byte_data};
      if (byte_cnt == LAST_BYTE) begin
        byte_cnt <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // The final byte bypasses the shift register so the top can register
  // the complete word on the same edge the byte is accepted.
  always_comb begin
    word       = {shreg, byte_data};
    word_valid = byte_en && (byte_cnt == LAST_BYTE);
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a big-endian byte stream into instruction memory as 32-bit words
// at consecutive word addresses from 0, holding the CPU while busy.
// Optional feature macro: ILOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte checked in a CHECK state.
module instruction_loader
  import iloader_pkg::*;
#(
  parameter int unsigned DEPTH  = IM_DEPTH,
  parameter int unsigned ADDR_W = IM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t          state;
  logic [ADDR_W:0] wc_q;
  logic [ADDR_W:0] waddr_cnt;
  logic            accept;
  logic            asm_en;
  logic            start_ok;
  logic            last_word;
  logic [31:0]     word;
  logic            word_valid;

  // Handshake and load-control decodes.
  always_comb begin
    accept    = byte_valid && byte_ready;
    asm_en    = accept && (state == S_LOAD);
    start_ok  = (state == S_IDLE) && start && (word_count != '0)
                && (word_count <= DEPTH_LIM);
    last_word = (waddr_cnt == (wc_q - 1'b1));
    cpu_hold  = busy;
  end

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (asm_en),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Write register stage: one-cycle im_we per assembled word, address
  // counter advances with each write. The counter is one bit wider than
  // the address so a full-depth load does not alias back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_we     <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      waddr_cnt <= '0;
    end else begin
      im_we <= 1'b0;
      if (start_ok) begin
        waddr_cnt <= '0;
      end else if (word_valid) begin
        im_we     <= 1'b1;
        im_wdata  <= word;
        im_waddr  <= waddr_cnt[ADDR_W-1:0];
        waddr_cnt <= waddr_cnt + 1'b1;
      end
    end
  end

`ifdef ILOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over payload bytes of the current load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (asm_en) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  // Load sequencing FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wc_q       <= '0;
      busy       <= 1'b0;
      byte_ready <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state <= S_FIN;
              busy  <= 1'b1;
              done  <= 1'b1;
              err   <= 1'b0;
            end else if (word_count > DEPTH_LIM) begin
              err <= 1'b1;
            end else begin
              wc_q       <= word_count;
              err        <= 1'b0;
              state      <= S_LOAD;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (word_valid && last_word) begin
`ifdef ILOADER_CHECKSUM_EN
            state <= S_CHECK;
`else
            state      <= S_FIN;
            byte_ready <= 1'b0;
            done       <= 1'b1;
`endif
          end
        end
`ifdef ILOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            err        <= (byte_data != csum);
            state      <= S_FIN;
            byte_ready <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: a byte-counting reference
// model is compared against the DUT every cycle, plus literal checks on
// memory contents, write counts and done pulses per scenario.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        im_we;
  logic [4:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  instruction_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs for the current cycle.
  int          m_phase = 0;   // 0 idle, 1 payload, 2 await checksum, 3 finishing
  int          m_nb = 0;      // payload bytes accepted in this load
  int          m_nw = 0;      // words requested
  logic [31:0] m_word = '0;
  logic [7:0]  m_x = '0;
  logic        e_we = 0, e_done = 0, e_busy = 0, e_ready = 0, e_err = 0;
  int          e_waddr = 0;
  logic [31:0] e_wdata = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0; m_nb = 0; m_nw = 0; m_word = '0; m_x = '0;
        e_we = 0; e_done = 0; e_busy = 0; e_ready = 0; e_err = 0;
        e_waddr = 0; e_wdata = '0;
      end else begin
        logic acc;
        acc = byte_valid && e_ready;
        e_we = 0;
        e_done = 0;
        case (m_phase)
          0: if (start) begin
            if (word_count == 0) begin
              m_phase = 3; e_done = 1; e_busy = 1; e_err = 0;
            end else if (int'(word_count) > 32) begin
              e_err = 1;
            end else begin
              m_phase = 1; m_nw = int'(word_count); m_nb = 0; m_word = '0; m_x = '0;
              e_err = 0; e_busy = 1; e_ready = 1;
            end
          end
          1: if (acc) begin
            m_word = m_word | (32'(byte_data) << (8 * (3 - (m_nb % 4))));
            m_x = m_x ^ byte_data;
            m_nb++;
            if (m_nb % 4 == 0) begin
              e_we = 1; e_waddr = m_nb / 4 - 1; e_wdata = m_word; m_word = '0;
              if (m_nb / 4 == m_nw) begin
`ifdef ILOADER_CHECKSUM_EN
                m_phase = 2;
`else
                m_phase = 3; e_done = 1; e_ready = 0;
`endif
              end
            end
          end
          2: if (acc) begin
            e_err = (byte_data != m_x);
            m_phase = 3; e_done = 1; e_ready = 0;
          end
          default: begin
            m_phase = 0; e_busy = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison plus capture of what the DUT wrote.
  logic [31:0] tb_mem [0:31];
  int          n_wr = 0;
  int          n_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("im_we", 32'(im_we), 32'(e_we));
      if (e_we || reset) begin
        chk("im_waddr", 32'(im_waddr), 32'(e_waddr));
        chk("im_wdata", im_wdata, e_wdata);
      end
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("cpu_hold", 32'(cpu_hold), 32'(e_busy));
      chk("byte_ready", 32'(byte_ready), 32'(e_ready));
      chk("err", 32'(err), 32'(e_err));
      if (im_we === 1'b1) begin
        tb_mem[im_waddr] = im_wdata;
        n_wr++;
      end
      if (done === 1'b1) n_done++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] seq [0:7];

  task automatic clear_log();
    for (int i = 0; i < 32; i++) tb_mem[i] = 32'hDEADBEEF;
    n_wr = 0;
    n_done = 0;
  endtask

  task automatic do_start(input logic [5:0] wc);
    word_count = wc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    logic rdy;
    bit   ok;
    ok = 0;
    for (int g = 0; g < gaps; g++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_seq(input int n, input int maxgap);
    for (int i = 0; i < n; i++) send_byte(seq[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic send_csum(input int n, input logic [7:0] delta);
`ifdef ILOADER_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < n; i++) x = x ^ seq[i];
    send_byte(x ^ delta, 0);
`else
    if (n < 0 || delta != 0) byte_valid = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_two_words();
    seq[0] = 8'h20; seq[1] = 8'h08; seq[2] = 8'h00; seq[3] = 8'h0A;
    seq[4] = 8'h20; seq[5] = 8'h09; seq[6] = 8'h00; seq[7] = 8'h05;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_im_we", 32'(im_we), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Normal two-word load, continuous stream.
    clear_log();
    load_two_words();
    do_start(6'd2);
    send_seq(8, 0);
    send_csum(8, 8'h00);
    wait_idle();
    chk("normal_mem0", tb_mem[0], 32'h2008000A);
    chk("normal_mem1", tb_mem[1], 32'h20090005);
    chk("normal_writes", n_wr, 2);
    chk("normal_dones", n_done, 1);
    chk("normal_hold", 32'(cpu_hold), 32'd0);

    // Same load with random gaps in byte_valid.
    clear_log();
    do_start(6'd2);
    send_seq(8, 3);
    send_csum(8, 8'h00);
    wait_idle();
    chk("gap_mem0", tb_mem[0], 32'h2008000A);
    chk("gap_mem1", tb_mem[1], 32'h20090005);
    chk("gap_writes", n_wr, 2);
    chk("gap_dones", n_done, 1);

    // Zero-length load.
    clear_log();
    do_start(6'd0);
    @(negedge clk);
    chk("zero_done_next", 32'(done), 32'd1);
    @(posedge clk); #1;
    wait_idle();
    chk("zero_writes", n_wr, 0);
    chk("zero_dones", n_done, 1);

    // Oversize request, then a valid start clears err.
    clear_log();
    do_start(6'd33);
    @(negedge clk);
    chk("over_err", 32'(err), 32'd1);
    chk("over_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("over_writes", n_wr, 0);
    seq[0] = 8'h8C; seq[1] = 8'h22; seq[2] = 8'h00; seq[3] = 8'h04;
    do_start(6'd1);
    @(negedge clk);
    chk("over_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    send_seq(4, 0);
    send_csum(4, 8'h00);
    wait_idle();
    chk("over_after_mem0", tb_mem[0], 32'h8C220004);
    chk("over_after_writes", n_wr, 1);

    // Reset after six bytes of a two-word load.
    clear_log();
    load_two_words();
    do_start(6'd2);
    send_seq(6, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_writes", n_wr, 1);
    chk("rst_mem0", tb_mem[0], 32'h2008000A);
    chk("rst_mem1", tb_mem[1], 32'hDEADBEEF);
    clear_log();
    seq[0] = 8'h24; seq[1] = 8'h0A; seq[2] = 8'h00; seq[3] = 8'h07;
    do_start(6'd1);
    send_seq(4, 0);
    send_csum(4, 8'h00);
    wait_idle();
    chk("restart_mem0", tb_mem[0], 32'h240A0007);
    chk("restart_writes", n_wr, 1);

`ifdef ILOADER_CHECKSUM_EN
    // Checksum: 20^08^00^0A = 0x22.
    clear_log();
    seq[0] = 8'h20; seq[1] = 8'h08; seq[2] = 8'h00; seq[3] = 8'h0A;
    do_start(6'd1);
    send_seq(4, 0);
    send_byte(8'h22, 0);
    wait_idle();
    chk("csum_ok_err", 32'(err), 32'd0);
    chk("csum_ok_mem0", tb_mem[0], 32'h2008000A);
    clear_log();
    do_start(6'd1);
    send_seq(4, 0);
    send_byte(8'h23, 0);
    wait_idle();
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_mem0", tb_mem[0], 32'h2008000A);
    chk("csum_bad_dones", n_done, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Write-side companion to the processor's instruction memory. It accepts a big-endian byte stream from an external host, assembles each group of four bytes into a 32-bit MIPS instruction word, and issues single-cycle word writes to consecutive instruction-memory addresses starting at word 0. It holds the CPU idle while loading and pulses `done` when the program image is in place.

## Interface
- `DEPTH`, 32: number of instruction words in instruction memory.
- `ADDR_W`, 5: word-address width, equal to log2(`DEPTH`).
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: begins a load. Sampled only in IDLE; ignored while busy.
- `word_count`  in  ADDR_W+1: number of words to load. Latched when `start` is accepted.
- `byte_valid`  in  1: host byte stream valid.
- `byte_data`  in  8: host byte.
- `byte_ready`  out  1: loader can accept a byte.
- `im_we`  out  1: instruction-memory write enable, a one-cycle pulse.
- `im_waddr`  out  ADDR_W: word address of the write.
- `im_wdata`  out  32: instruction word being written.
- `cpu_hold`  out  1: stalls PC/CPU while a load is in progress.
- `busy`  out  1: FSM is not in IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: sticky error flag. Cleared on the next accepted `start`.

## Operation
- Reset values: every output is 0, FSM is in IDLE, word address counter is 0, byte counter is 0.
- FSM states: IDLE, LOAD, CHECK (only when the checksum feature is compiled in), FIN.
- IDLE, `start`=1:
  - `word_count` = 0: go to FIN. No writes.
  - `word_count` > `DEPTH`: set `err`, stay in IDLE. No writes.
  - Otherwise: latch `word_count`, clear `err`, clear both counters, go to LOAD.
- Byte transfer: a byte is accepted on any edge where `byte_valid` and `byte_ready` are both 1.
- Word assembly: the first byte of each word lands in [31:24], the second in [23:16], the third in [15:8], the fourth in [7:0].
- Word write: on acceptance of the 4th byte, the next cycle drives `im_we`=1, `im_wdata`=the assembled word, and `im_waddr`=the current word address. The word address increments after that write.
- `byte_ready`=1 in LOAD and CHECK. Streaming continues during a write cycle, so back-to-back words need no bubble.
- Leaving LOAD: on acceptance of the 4th byte of the final word, the FSM leaves LOAD at that same edge, going to CHECK or FIN. `byte_ready` is 0 from the next cycle onward.
- FIN lasts one cycle, with `done`=1, then the FSM returns to IDLE. The final word's `im_we` pulse coincides with FIN when checksum is disabled.
- `busy` = (state ≠ IDLE). `cpu_hold` = `busy`.
- Reset mid-load: everything returns immediately to reset values. A partially assembled word is discarded and never written. Words already written remain in memory.
- The word address never wraps. It is bounded by the `word_count` ≤ `DEPTH` check.

## Timing
- Latency: 4th byte accepted at edge N; `im_we` is high between edges N and N+1; memory commits the word at edge N+1.
- Sustained throughput: one word per 4 cycles when `byte_valid` is held at 1.
- `done` asserts exactly once per successful or zero-length load, one cycle after the last write-triggering byte (or after `start` for `word_count` = 0).
- `start` asserted together with `reset`: reset wins.

## Configuration
- `ILOADER_CHECKSUM_EN` defined:
  - A running XOR of all payload bytes is kept.
  - After the final word, the FSM enters CHECK and accepts one more byte.
  - A mismatch with the running XOR sets `err`.
  - The FSM then goes to FIN and `done` pulses either way. Writes are never suppressed.
- `ILOADER_CHECKSUM_EN` undefined: no CHECK state, no checksum byte, and `err` is set only by an oversize `word_count`.

## Structure
- Package `iloader_pkg` holds:
  - the FSM state enum;
  - `IM_DEPTH` = 32;
  - `WORD_BYTES` = 4;
  - `IM_ADDR_W` = 5.
- Sub-module `word_assembler` holds the byte shift register and 2-bit byte counter. It outputs an assembled word plus a one-cycle `word_valid`.
- The top level holds the FSM, address counter, write register stage, and the optional checksum.

## Test plan
- Normal load:
  - Stimulus: `word_count`=2, bytes 20 08 00 0A 20 09 00 05 streamed continuously.
  - Response: writes addr0=0x2008000A then addr1=0x20090005, one `done` pulse, `cpu_hold` low the cycle after FIN.
- Backpressure gaps:
  - Stimulus: same two words with `byte_valid` toggling randomly.
  - Response: identical writes and addresses, no extra `im_we` pulses.
- Zero length:
  - Stimulus: `word_count`=0.
  - Response: `done` one cycle after `start`, no `im_we`.
- Oversize:
  - Stimulus: `word_count`=33.
  - Response: `err`=1, no writes, `busy` stays 0. A following valid `start` clears `err`.
- Reset mid-load:
  - Stimulus: assert `reset` after 6 bytes of a 2-word load.
  - Response: addr0 written, addr1 never written, all outputs 0. A new load restarts at addr0.
- Checksum (`ILOADER_CHECKSUM_EN` defined):
  - Stimulus: `word_count`=1, bytes 20 08 00 0A, then checksum byte 0x22.
  - Response: `err`=0.
  - Stimulus: same load with checksum byte 0x23.
  - Response: `err`=1, the word is still written, and `done` still pulses.
